hsv2rgb_pipe: RTL and testbench

//  Parametrised, fully pipelined HSV->RGB converter for the colour-reduction video path; successor to the single-stage converter.

---
 rtl/hsv2rgb_pipe.sv | 225 ++++++++++++++++++++++
 tb/tb_hsv2rgb_pipe.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/hsv2rgb_pipe.sv
// Four-stage pipelined HSV->RGB converter with valid/ready handshake and sideband tag.
// Define HSV2RGB_LEGACY_RBG_EN to pack out_rgb as {R,B,G} for the legacy display packer.
module hsv2rgb_pipe #(
    parameter int W     = 8,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3*W-1:0]     in_hsv,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [3*W-1:0]     out_rgb,
    output logic [TAG_W-1:0]   out_tag
);

    localparam logic [W-1:0] MAX = {W{1'b1}};

    localparam logic [2:0] SEC_0 = 3'd0;
    localparam logic [2:0] SEC_1 = 3'd1;
    localparam logic [2:0] SEC_2 = 3'd2;
    localparam logic [2:0] SEC_3 = 3'd3;
    localparam logic [2:0] SEC_4 = 3'd4;
    localparam logic [2:0] SEC_5 = 3'd5;

    logic adv;

    // Stage 1: captured input
    logic             valid1_q, valid1_d;
    logic [W-1:0]     h1_q, h1_d;
    logic [W-1:0]     s1_q, s1_d;
    logic [W-1:0]     v1_q, v1_d;
    logic [TAG_W-1:0] tag1_q, tag1_d;

    // Stage 2: a, b, P
    logic             valid2_q, valid2_d;
    logic [W-1:0]     a2_q, a2_d;
    logic [W-1:0]     b2_q, b2_d;
    logic [W-1:0]     p2_q, p2_d;
    logic [W-1:0]     v2_q, v2_d;
    logic [2:0]       sector2_q, sector2_d;
    logic             szero2_q, szero2_d;
    logic [TAG_W-1:0] tag2_q, tag2_d;

    // Stage 3: P, Q, T
    logic             valid3_q, valid3_d;
    logic [W-1:0]     p3_q, p3_d;
    logic [W-1:0]     q3_q, q3_d;
    logic [W-1:0]     t3_q, t3_d;
    logic [W-1:0]     v3_q, v3_d;
    logic [2:0]       sector3_q, sector3_d;
    logic             szero3_q, szero3_d;
    logic [TAG_W-1:0] tag3_q, tag3_d;

    // Stage 4: output register
    logic             out_valid_q, out_valid_d;
    logic [3*W-1:0]   out_rgb_q, out_rgb_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;

    // Datapath intermediates
    logic [W+2:0]     h6;
    logic [2:0]       sector1;
    logic [W-1:0]     f1;
    logic [2*W-1:0]   prod_a, prod_b, prod_p;
    logic [2*W-1:0]   prod_q, prod_t;
    logic [W-1:0]     r4, g4, b4;

    assign adv      = ~out_valid_q | out_ready;
    assign in_ready = adv;

    assign out_valid = out_valid_q;
    assign out_rgb   = out_rgb_q;
    assign out_tag   = out_tag_q;

    // Hue sector and fraction come from H*6 split at bit W, avoiding a divider.
    always_comb begin
        h6      = {3'b000, h1_q} * (W+3)'(6);
        sector1 = h6[W+2:W];
        f1      = h6[W-1:0];
        prod_a  = {{W{1'b0}}, s1_q} * {{W{1'b0}}, f1};
        prod_b  = {{W{1'b0}}, s1_q} * {{W{1'b0}}, MAX - f1};
        prod_p  = {{W{1'b0}}, v1_q} * {{W{1'b0}}, MAX - s1_q};
        prod_q  = {{W{1'b0}}, v2_q} * {{W{1'b0}}, MAX - a2_q};
        prod_t  = {{W{1'b0}}, v2_q} * {{W{1'b0}}, MAX - b2_q};
    end

    always_comb begin
        r4 = '0;
        g4 = '0;
        b4 = '0;
        if (szero3_q) begin
            r4 = v3_q;
            g4 = v3_q;
            b4 = v3_q;
        end else begin
            case (sector3_q)
                SEC_0: begin r4 = v3_q; g4 = t3_q; b4 = p3_q; end
                SEC_1: begin r4 = q3_q; g4 = v3_q; b4 = p3_q; end
                SEC_2: begin r4 = p3_q; g4 = v3_q; b4 = t3_q; end
                SEC_3: begin r4 = p3_q; g4 = q3_q; b4 = v3_q; end
                SEC_4: begin r4 = t3_q; g4 = p3_q; b4 = v3_q; end
                SEC_5: begin r4 = v3_q; g4 = p3_q; b4 = q3_q; end
                default: begin r4 = '0; g4 = '0; b4 = '0; end
            endcase
        end
    end

    // Whole-pipe advance: every stage loads together or all hold.
    always_comb begin
        valid1_d    = valid1_q;
        h1_d        = h1_q;
        s1_d        = s1_q;
        v1_d        = v1_q;
        tag1_d      = tag1_q;
        valid2_d    = valid2_q;
        a2_d        = a2_q;
        b2_d        = b2_q;
        p2_d        = p2_q;
        v2_d        = v2_q;
        sector2_d   = sector2_q;
        szero2_d    = szero2_q;
        tag2_d      = tag2_q;
        valid3_d    = valid3_q;
        p3_d        = p3_q;
        q3_d        = q3_q;
        t3_d        = t3_q;
        v3_d        = v3_q;
        sector3_d   = sector3_q;
        szero3_d    = szero3_q;
        tag3_d      = tag3_q;
        out_valid_d = out_valid_q;
        out_rgb_d   = out_rgb_q;
        out_tag_d   = out_tag_q;
        if (adv) begin
            valid1_d    = in_valid;
            h1_d        = in_hsv[3*W-1:2*W];
            s1_d        = in_hsv[2*W-1:W];
            v1_d        = in_hsv[W-1:0];
            tag1_d      = in_tag;

            valid2_d    = valid1_q;
            a2_d        = W'(prod_a >> W);
            b2_d        = W'(prod_b >> W);
            p2_d        = W'(prod_p >> W);
            v2_d        = v1_q;
            sector2_d   = sector1;
            szero2_d    = (s1_q == '0);
            tag2_d      = tag1_q;

            valid3_d    = valid2_q;
            p3_d        = p2_q;
            q3_d        = W'(prod_q >> W);
            t3_d        = W'(prod_t >> W);
            v3_d        = v2_q;
            sector3_d   = sector2_q;
            szero3_d    = szero2_q;
            tag3_d      = tag2_q;

            out_valid_d = valid3_q;
`ifdef HSV2RGB_LEGACY_RBG_EN
            out_rgb_d   = {r4, b4, g4};
`else
            out_rgb_d   = {r4, g4, b4};
`endif
            out_tag_d   = tag3_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid1_q    <= 1'b0;
            h1_q        <= '0;
            s1_q        <= '0;
            v1_q        <= '0;
            tag1_q      <= '0;
            valid2_q    <= 1'b0;
            a2_q        <= '0;
            b2_q        <= '0;
            p2_q        <= '0;
            v2_q        <= '0;
            sector2_q   <= '0;
            szero2_q    <= 1'b0;
            tag2_q      <= '0;
            valid3_q    <= 1'b0;
            p3_q        <= '0;
            q3_q        <= '0;
            t3_q        <= '0;
            v3_q        <= '0;
            sector3_q   <= '0;
            szero3_q    <= 1'b0;
            tag3_q      <= '0;
            out_valid_q <= 1'b0;
            out_rgb_q   <= '0;
            out_tag_q   <= '0;
        end else begin
            valid1_q    <= valid1_d;
            h1_q        <= h1_d;
            s1_q        <= s1_d;
            v1_q        <= v1_d;
            tag1_q      <= tag1_d;
            valid2_q    <= valid2_d;
            a2_q        <= a2_d;
            b2_q        <= b2_d;
            p2_q        <= p2_d;
            v2_q        <= v2_d;
            sector2_q   <= sector2_d;
            szero2_q    <= szero2_d;
            tag2_q      <= tag2_d;
            valid3_q    <= valid3_d;
            p3_q        <= p3_d;
            q3_q        <= q3_d;
            t3_q        <= t3_d;
            v3_q        <= v3_d;
            sector3_q   <= sector3_d;
            szero3_q    <= szero3_d;
            tag3_q      <= tag3_d;
            out_valid_q <= out_valid_d;
            out_rgb_q   <= out_rgb_d;
            out_tag_q   <= out_tag_d;
        end
    end

endmodule

// File: tb/tb_hsv2rgb_pipe.sv
// Self-checking bench for hsv2rgb_pipe: directed vectors, reset, stall and hue sweep.
// Expected packing follows HSV2RGB_LEGACY_RBG_EN when it is defined for the build.
module tb_hsv2rgb_pipe;

    localparam int W     = 8;
    localparam int TAG_W = 4;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               in_valid;
    logic               in_ready;
    logic [3*W-1:0]     in_hsv;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [3*W-1:0]     out_rgb;
    logic [TAG_W-1:0]   out_tag;

    int testsRun = 0;
    int testsFailed = 0;

    logic [27:0] expQ[$];
    logic [27:0] pendingExp;
    logic        prevStall = 1'b0;
    logic [27:0] prevOut;
    int          cycleNo = 0;
    int          outCount = 0;
    int          lastInCycle = -1;
    int          firstOutCycle = -1;
    logic        lastInXfer = 1'b0;

    hsv2rgb_pipe #(.W(W), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_hsv    (in_hsv),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_rgb   (out_rgb),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, observed, expected);
        end
    endtask

    function automatic logic [23:0] packRgb(input int r, input int g, input int b);
        logic [7:0] r8, g8, b8;
        r8 = r[7:0];
        g8 = g[7:0];
        b8 = b[7:0];
`ifdef HSV2RGB_LEGACY_RBG_EN
        return {r8, b8, g8};
`else
        return {r8, g8, b8};
`endif
    endfunction

    function automatic logic [23:0] refRgb(input int h, input int s, input int v);
        int h6, sec, f, a, b, p, q, t;
        h6  = h * 6;
        sec = h6 / 256;
        f   = h6 % 256;
        a   = (s * f) / 256;
        b   = (s * (255 - f)) / 256;
        p   = (v * (255 - s)) / 256;
        q   = (v * (255 - a)) / 256;
        t   = (v * (255 - b)) / 256;
        if (s == 0) return packRgb(v, v, v);
        case (sec)
            0: return packRgb(v, t, p);
            1: return packRgb(q, v, p);
            2: return packRgb(p, v, t);
            3: return packRgb(p, q, v);
            4: return packRgb(t, p, v);
            5: return packRgb(v, p, q);
            default: return 24'h0;
        endcase
    endfunction

    task automatic applyStimulus(input logic valid, input int h, input int s, input int v,
                                 input int tag, input logic [23:0] expRgb);
        logic [3:0] tag4;
        tag4       = tag[3:0];
        in_valid   = valid;
        in_hsv     = {h[7:0], s[7:0], v[7:0]};
        in_tag     = tag4;
        pendingExp = {tag4, expRgb};
    endtask

    // One clock: sample at the falling edge, score transfers, then step past the rising edge.
    task automatic runCycle();
        logic [27:0] e;
        @(negedge clk);
        lastInXfer = 1'b0;
        if (!reset_n) begin
            checkOutput("reset_out_valid", {31'b0, out_valid}, 32'd0);
            checkOutput("reset_out_rgb", {8'b0, out_rgb}, 32'd0);
            expQ.delete();
            prevStall = 1'b0;
        end else begin
            if (out_valid && !out_ready)
                checkOutput("in_ready_stall", {31'b0, in_ready}, 32'd0);
            if (prevStall)
                checkOutput("stall_hold", {4'b0, out_tag, out_rgb}, {4'b0, prevOut});
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_out", 32'd1, 32'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("pixel", {4'b0, out_tag, out_rgb}, {4'b0, e});
                end
                outCount++;
                if (firstOutCycle < 0) firstOutCycle = cycleNo;
            end
            if (in_valid && in_ready) begin
                expQ.push_back(pendingExp);
                lastInXfer  = 1'b1;
                lastInCycle = cycleNo;
            end
            prevStall = out_valid && !out_ready;
            prevOut   = {out_tag, out_rgb};
        end
        cycleNo++;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        applyStimulus(1'b0, 0, 0, 0, 0, 24'h0);
        out_ready = 1'b1;
        n = 0;
        while (expQ.size() != 0 && n < 40) begin
            runCycle();
            n++;
        end
        if (expQ.size() != 0) checkOutput("drain_timeout", expQ.size(), 32'd0);
    endtask

    initial begin
        int sent, startOut, budget;
        reset_n   = 1'b0;
        out_ready = 1'b1;
        applyStimulus(1'b0, 0, 0, 0, 0, 24'h0);
        runCycle();
        runCycle();
        checkOutput("reset_out_tag", {28'b0, out_tag}, 32'd0);
        reset_n = 1'b1;
        runCycle();
        checkOutput("in_ready_after_reset", {31'b0, in_ready}, 32'd1);

        $display("[TB] directed vectors");
        applyStimulus(1'b1, 0,   255, 255, 1, packRgb(255, 0, 0));     runCycle();
        applyStimulus(1'b1, 43,  255, 255, 2, packRgb(253, 255, 0));   runCycle();
        applyStimulus(1'b1, 128, 255, 255, 3, packRgb(0, 254, 255));   runCycle();
        applyStimulus(1'b1, 77,  0,   128, 4, packRgb(128, 128, 128)); runCycle();
        applyStimulus(1'b1, 200, 255, 0,   5, packRgb(0, 0, 0));       runCycle();
        drain();

        $display("[TB] reset mid-stream and latency");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 10 * i, 255, 255, 6 + i, packRgb(0, 0, 0));
            runCycle();
        end
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) runCycle();
        reset_n = 1'b1;
        firstOutCycle = -1;
        applyStimulus(1'b1, 0, 255, 255, 9, packRgb(255, 0, 0));
        runCycle();
        checkOutput("post_reset_xfer", {31'b0, lastInXfer}, 32'd1);
        drain();
        checkOutput("latency", firstOutCycle - lastInCycle, 32'd4);

        $display("[TB] random backpressure stream");
        sent = 0;
        startOut = outCount;
        budget = 0;
        while ((outCount - startOut) < 16 && budget < 400) begin
            if (sent < 16)
                applyStimulus(1'b1, 16 * sent + 5, 230, 210, sent,
                              refRgb(16 * sent + 5, 230, 210));
            else
                applyStimulus(1'b0, 0, 0, 0, 0, 24'h0);
            out_ready = 1'($urandom_range(0, 1));
            runCycle();
            if (lastInXfer) sent++;
            budget++;
        end
        checkOutput("stream_count", outCount - startOut, 32'd16);
        drain();

        $display("[TB] hue sweep");
        out_ready = 1'b1;
        for (int h = 0; h < 256; h++) begin
            applyStimulus(1'b1, h, 200, 180, h % 16, refRgb(h, 200, 180));
            runCycle();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
